ob_cmd_deser: RTL and testbench
===============================

// Module: ob_cmd_deser
// PURPOSE
//  Ingress stage upstream of the order book. Assembles framed commands from a byte stream
//  into ob_pkg::cmd_t and issues them on the cmd_vld_r/cmd_r/cmd_full_r interface.
//  Each frame is checked for a valid start byte, checksum and inter-byte gap; bad frames
//  are dropped and counted.
// PARAMETERS
//  CMD_BYTES   ob_pkg::CMD_BYTES  payload bytes per frame; equals ceil($bits(cmd_t)/8)
//  SOF         8'hA5              start-of-frame byte
//  TIMEOUT_N   64                 maximum idle cycles between bytes inside one frame
//  STAT_W      16                 width of the statistics counters
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  in_vld         in   1          byte valid
//  in_data        in   8          byte data
//  in_rdy         out  1          byte accepted when in_vld & in_rdy
//  cmd_vld_r      out  1          registered one-cycle pulse; cmd_r is valid in that cycle
//  cmd_r          out  cmd_t      assembled command (ob_pkg::cmd_t)
//  cmd_full_r     in   1          registered full flag from the order book ingress queue
//  stat_frames_r  out  STAT_W     count of good frames issued (saturating)
//  stat_err_r     out  STAT_W     count of dropped frames: checksum or timeout (saturating)
// BEHAVIOUR
//  Reset: state=IDLE; in_rdy=0 in the cycle of reset; cmd_vld_r=0; cmd_r=0; both stats=0.
//  FSM states:
//  - IDLE: in_rdy=1. Accepted byte == SOF -> PAY, idx=0, csum=0. Any other byte is
//    discarded; the error counter does not increment.
//  - PAY: in_rdy=1. Each accepted byte goes into shift reg (first byte = MSBs of cmd_t);
//    csum ^= byte. When idx == CMD_BYTES-1 -> CHK. Surplus MSB pad bits are discarded.
//  - CHK: in_rdy=1. Accepted byte == csum -> ISS. Otherwise stat_err++ and -> IDLE.
//  - ISS: in_rdy=0. If cmd_full_r==0, set cmd_vld_r=1 for exactly one cycle,
//    stat_frames++ and -> IDLE. If cmd_full_r==1, hold indefinitely with no timeout.
//  Timeout:
//  - Gap counter resets on every accepted byte and counts cycles in PAY and CHK.
//  - When the counter reaches TIMEOUT_N: stat_err++, -> IDLE, partial frame discarded.
//  - A byte accepted in the same cycle as the expiry wins; no timeout occurs.
//  Latency: cmd_vld_r asserts 1 cycle after the checksum byte is accepted, when not full.
//  Backpressure: a frame takes at least CMD_BYTES+2 cycles, so two cmd_vld_r pulses can
//  never be adjacent. The one-cycle lag of cmd_full_r therefore cannot overflow the queue.
//  cmd_r keeps its value after issue until the next issue.
//  Counters saturate at all-ones. A frame error and an issue cannot occur in the same cycle.
//  SOF has no special meaning inside PAY or CHK; it is treated as data.
//  Reset mid-frame: the partial frame is lost, no pulse is emitted, stats clear.
// STRUCTURE
//  ob_pkg holds: cmd_t, CMD_BYTES, and the deser_state_t enum {IDLE, PAY, CHK, ISS}.
//  A single flat module holds the FSM, shift register, checksum, gap counter and stats.
//  One sub-module is natural: ob_sat_cnt #(.W(STAT_W)), instanced twice for the stats.
// TESTING
//  1. SOF, CMD_BYTES payload bytes, correct XOR, cmd_full_r=0
//     -> one cmd_vld_r pulse, cmd_r == packed payload, stat_frames_r=1.
//  2. Same frame with checksum ^ 8'h01
//     -> no pulse, stat_err_r=1, FSM back in IDLE; the next good frame issues.
//  3. Garbage 8'h00,8'h13 then a good frame
//     -> exactly one pulse, stat_err_r=0.
//  4. Stall TIMEOUT_N cycles after payload byte 2
//     -> stat_err_r=1, no pulse.
//     Same stall of TIMEOUT_N-1 cycles -> frame completes normally.
//  5. cmd_full_r=1 for 20 cycles at ISS
//     -> in_rdy=0, no pulse; pulse in the first cycle after cmd_full_r falls.
//  6. Assert rst at payload byte 3
//     -> outputs and stats zero; a following good frame issues correctly.
//  Continuous checks on every run:
//  - in_vld held high with random data for 10k bytes: scoreboard matches every good frame.
//  - Assertion: cmd_vld_r is never high in two consecutive cycles.

Source files
------------

// File: rtl/ob_pkg.sv
// ----------------------------------------------------------------------------
// ob_pkg
// Shared types for the order-book ingress path.
//   cmd_t          : packed command as seen by the order book
//   CMD_BITS       : width of cmd_t
//   CMD_BYTES      : bytes needed to carry one cmd_t on the byte stream
//   deser_state_t  : framing FSM states of ob_cmd_deser
// ----------------------------------------------------------------------------
package ob_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_CANCEL = 2'd1,
        OP_MODIFY = 2'd2,
        OP_NOP    = 2'd3
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        side;
        logic [15:0] order_id;
        logic [15:0] price;
        logic [11:0] qty;
    } cmd_t;

    localparam int unsigned CMD_BITS  = $bits(cmd_t);
    localparam int unsigned CMD_BYTES = (CMD_BITS + 7) / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        CHK  = 2'd2,
        ISS  = 2'd3
    } deser_state_t;

endpackage

// File: rtl/ob_sat_cnt.sv
// ----------------------------------------------------------------------------
// ob_sat_cnt
// Saturating up-counter; sticks at all-ones.
//   clk    in   clock
//   rst    in   synchronous active-high reset (clears count)
//   inc_i  in   increment request
//   cnt_o  out  current count (W bits)
// ----------------------------------------------------------------------------
module ob_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ob_cmd_deser.sv
// ----------------------------------------------------------------------------
// ob_cmd_deser
// Assembles framed commands (SOF, CMD_BYTES payload, XOR checksum) from a byte
// stream into cmd_t and issues them to the order book ingress queue. Frames
// with a bad checksum or an over-long inter-byte gap are dropped and counted.
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   in_vld/in_data in   byte stream, accepted when in_vld & in_rdy
//   in_rdy         out  byte ready (low in ISS and while rst is high)
//   cmd_vld_r      out  registered one-cycle issue pulse
//   cmd_r          out  assembled command, held until the next issue
//   cmd_full_r     in   ingress queue full, blocks issue while high
//   stat_frames_r  out  saturating count of issued frames
//   stat_err_r     out  saturating count of dropped frames
// ----------------------------------------------------------------------------
module ob_cmd_deser
    import ob_pkg::*;
#(
    parameter int unsigned CMD_BYTES = ob_pkg::CMD_BYTES,
    parameter logic [7:0]  SOF       = 8'hA5,
    parameter int unsigned TIMEOUT_N = 64,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [7:0]        in_data,
    output logic              in_rdy,
    output logic              cmd_vld_r,
    output cmd_t              cmd_r,
    input  logic              cmd_full_r,
    output logic [STAT_W-1:0] stat_frames_r,
    output logic [STAT_W-1:0] stat_err_r
);

    localparam int unsigned IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int unsigned GAP_W = $clog2(TIMEOUT_N + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_N - 1);

    deser_state_t         state_q, state_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    // Only CMD_BITS are kept: pad MSBs of the first byte shift straight out.
    logic [CMD_BITS-1:0]  shift_q, shift_d;
    logic [7:0]           csum_q,  csum_d;
    logic [GAP_W-1:0]     gap_q,   gap_d;
    cmd_t                 cmd_q,   cmd_d;
    logic                 vld_q,   vld_d;
    logic                 frame_inc, err_inc;
    logic                 acc;

    assign in_rdy = ~rst & (state_q != ISS);
    assign acc    = in_vld & in_rdy;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        gap_d     = '0;
        cmd_d     = cmd_q;
        vld_d     = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc && (in_data == SOF)) begin
                    state_d = PAY;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            PAY: begin
                if (acc) begin
                    shift_d = CMD_BITS'({shift_q, in_data});
                    csum_d  = csum_q ^ in_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (gap_q == GAP_LAST) begin
                    // Expiry only fires on a cycle with no accepted byte.
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            CHK: begin
                if (acc) begin
                    if (in_data == csum_q) begin
                        state_d = ISS;
                    end else begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ISS: begin
                if (!cmd_full_r) begin
                    vld_d     = 1'b1;
                    cmd_d     = cmd_t'(shift_q);
                    frame_inc = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            gap_q   <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
        end
    end

    assign cmd_vld_r = vld_q;
    assign cmd_r     = cmd_q;

    ob_sat_cnt #(.W(STAT_W)) u_stat_frames (
        .clk   (clk),
        .rst   (rst),
        .inc_i (frame_inc),
        .cnt_o (stat_frames_r)
    );

    ob_sat_cnt #(.W(STAT_W)) u_stat_err (
        .clk   (clk),
        .rst   (rst),
        .inc_i (err_inc),
        .cnt_o (stat_err_r)
    );

endmodule

// File: tb/tb_ob_cmd_deser.sv
// ----------------------------------------------------------------------------
// tb_ob_cmd_deser
// Directed and streamed checks of ob_cmd_deser framing, checksum, timeout,
// backpressure, reset and statistics.
// ----------------------------------------------------------------------------
module tb_ob_cmd_deser;
    import ob_pkg::*;

    localparam int unsigned TO_N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [7:0]  in_data;
    logic        in_rdy;
    logic        cmd_vld_r;
    cmd_t        cmd_r;
    logic        cmd_full_r;
    logic [15:0] stat_frames_r;
    logic [15:0] stat_err_r;

    ob_cmd_deser #(
        .CMD_BYTES (6),
        .SOF       (8'hA5),
        .TIMEOUT_N (TO_N),
        .STAT_W    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_data       (in_data),
        .in_rdy        (in_rdy),
        .cmd_vld_r     (cmd_vld_r),
        .cmd_r         (cmd_r),
        .cmd_full_r    (cmd_full_r),
        .stat_frames_r (stat_frames_r),
        .stat_err_r    (stat_err_r)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_pulse = 0;
    logic        prev_vld = 1'b0;
    logic [46:0] last_cmd = '0;

    // Stream scoreboard state
    logic        sb_on = 1'b0;
    logic [46:0] exp_q[$];
    int unsigned m_st = 0;
    int unsigned m_idx = 0;
    logic [7:0]  m_cs = '0;
    logic [47:0] m_sh = '0;
    int unsigned m_frames = 0;
    int unsigned m_errs = 0;

    localparam logic [47:0] P1 = 48'h123456789ABC;  // csum 8'h2E
    localparam logic [47:0] P2 = 48'hF00102030405;  // csum 8'hF1, MSB pad bit set

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_st)
            0: if (b == 8'hA5) begin m_st = 1; m_idx = 0; m_cs = '0; end
            1: begin
                m_sh = {m_sh[39:0], b};
                m_cs = m_cs ^ b;
                if (m_idx == 5) m_st = 2; else m_idx++;
            end
            default: begin
                if (b == m_cs) begin exp_q.push_back(m_sh[46:0]); m_frames++; end
                else m_errs++;
                m_st = 0;
            end
        endcase
    endtask

    // Returns #1 after the edge that accepted the byte; in_vld stays high.
    task automatic send_byte(input logic [7:0] b);
        int unsigned waitc = 0;
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = b;
        while (!in_rdy && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_rdy) begin
            check("rdy_wait", 64'(in_rdy), 64'd1);
        end else begin
            @(posedge clk);
            #1;
            if (sb_on) model_byte(b);
        end
    endtask

    task automatic send_frame(input logic [47:0] pl, input logic [7:0] cs);
        send_byte(8'hA5);
        for (int unsigned i = 0; i < 6; i++) send_byte(pl[47 - 8*i -: 8]);
        send_byte(cs);
    endtask

    task automatic idle(input int unsigned n);
        in_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_vld",    64'(cmd_vld_r), 64'd0);
        check("rst_cmd",    64'(cmd_r), 64'd0);
        check("rst_frames", 64'(stat_frames_r), 64'd0);
        check("rst_err",    64'(stat_err_r), 64'd0);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [47:0] pl);
        logic [7:0] c = '0;
        for (int unsigned i = 0; i < 6; i++) c = c ^ pl[8*i +: 8];
        return c;
    endfunction

    // Pulse monitor: adjacency check and stream scoreboard
    always @(negedge clk) begin
        if (cmd_vld_r) begin
            n_pulse++;
            last_cmd = cmd_r;
            check("vld_adjacent", 64'(prev_vld), 64'd0);
            if (sb_on) begin
                if (exp_q.size() == 0) check("sb_unexpected_pulse", 64'(exp_q.size()), 64'd1);
                else check("sb_cmd", 64'(cmd_r), 64'(exp_q.pop_front()));
            end
        end
        prev_vld = cmd_vld_r;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned p0;
        logic        rdy_seen;
        logic [47:0] pl;
        int unsigned nbytes;

        rst        = 1'b1;
        in_vld     = 1'b0;
        in_data    = '0;
        cmd_full_r = 1'b0;
        do_reset();

        // 1: good frame, latency and content
        p0 = n_pulse;
        send_frame(P1, 8'h2E);
        in_vld = 1'b0;
        @(negedge clk);
        check("t1_iss_rdy", 64'(in_rdy), 64'd0);
        check("t1_vld_early", 64'(cmd_vld_r), 64'd0);
        @(negedge clk);
        check("t1_vld", 64'(cmd_vld_r), 64'd1);
        idle(3);
        check("t1_pulses", 64'(n_pulse - p0), 64'd1);
        check("t1_cmd", 64'(last_cmd), 64'h123456789ABC);
        check("t1_frames", 64'(stat_frames_r), 64'd1);
        check("t1_err", 64'(stat_err_r), 64'd0);

        // 2: bad checksum, then good frame with MSB pad bit dropped
        p0 = n_pulse;
        send_frame(P1, 8'h2F);
        idle(4);
        check("t2_pulses_bad", 64'(n_pulse - p0), 64'd0);
        check("t2_err", 64'(stat_err_r), 64'd1);
        send_frame(P2, 8'hF1);
        idle(4);
        check("t2_pulses_good", 64'(n_pulse - p0), 64'd1);
        check("t2_cmd", 64'(cmd_r), 64'h700102030405);
        check("t2_frames", 64'(stat_frames_r), 64'd2);

        // 3: garbage ahead of a frame
        p0 = n_pulse;
        send_byte(8'h00);
        send_byte(8'h13);
        send_frame(P1, 8'h2E);
        idle(4);
        check("t3_pulses", 64'(n_pulse - p0), 64'd1);
        check("t3_err", 64'(stat_err_r), 64'd1);
        check("t3_cmd", 64'(cmd_r), 64'h123456789ABC);

        // 4a: TIMEOUT_N idle cycles after payload byte 2 -> dropped
        p0 = n_pulse;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        idle(TO_N);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
        send_byte(8'hBC); send_byte(8'h2E);
        idle(4);
        check("t4_timeout_pulses", 64'(n_pulse - p0), 64'd0);
        check("t4_timeout_err", 64'(stat_err_r), 64'd2);

        // 4b: TIMEOUT_N-1 idle cycles -> frame completes
        p0 = n_pulse;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        idle(TO_N - 1);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
        send_byte(8'hBC); send_byte(8'h2E);
        idle(4);
        check("t4_gap_ok_pulses", 64'(n_pulse - p0), 64'd1);
        check("t4_gap_ok_err", 64'(stat_err_r), 64'd2);
        check("t4_gap_ok_frames", 64'(stat_frames_r), 64'd4);

        // 5: held at ISS by cmd_full_r for 20 cycles
        p0 = n_pulse;
        cmd_full_r = 1'b1;
        send_frame(P2, 8'hF1);
        in_vld   = 1'b0;
        rdy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            rdy_seen = rdy_seen | in_rdy;
        end
        check("t5_full_rdy", 64'(rdy_seen), 64'd0);
        check("t5_full_pulses", 64'(n_pulse - p0), 64'd0);
        cmd_full_r = 1'b0;
        @(negedge clk);
        check("t5_release_vld", 64'(cmd_vld_r), 64'd1);
        idle(3);
        check("t5_pulses", 64'(n_pulse - p0), 64'd1);
        check("t5_frames", 64'(stat_frames_r), 64'd5);

        // 6: reset mid-frame
        p0 = n_pulse;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        do_reset();
        send_frame(P2, 8'hF1);
        idle(4);
        check("t6_pulses", 64'(n_pulse - p0), 64'd1);
        check("t6_cmd", 64'(cmd_r), 64'h700102030405);
        check("t6_frames", 64'(stat_frames_r), 64'd1);
        check("t6_err", 64'(stat_err_r), 64'd0);

        // 7: continuous stream of mixed frames and garbage against the scoreboard
        do_reset();
        sb_on  = 1'b1;
        nbytes = 0;
        while (nbytes < 10000) begin
            case ($urandom_range(0, 3))
                0: begin
                    send_byte(8'($urandom));
                    nbytes += 1;
                end
                3: begin
                    pl = {16'($urandom), 32'($urandom)};
                    send_frame(pl, xsum(pl) ^ (8'd1 << $urandom_range(0, 7)));
                    nbytes += 8;
                end
                default: begin
                    pl = {16'($urandom), 32'($urandom)};
                    send_frame(pl, xsum(pl));
                    nbytes += 8;
                end
            endcase
        end
        idle(10);
        check("t7_queue_left", 64'(exp_q.size()), 64'd0);
        check("t7_frames", 64'(stat_frames_r), 64'(m_frames));
        check("t7_err", 64'(stat_err_r), 64'(m_errs));
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
